// File: rtl/vram_pkg.sv
// Constants and types shared by the VRAM responder, the vga block and the CPU bus decode.
package vram_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;
    localparam int VRAM_DEPTH  = 8192;

    typedef enum logic {
        C_IDLE = 1'b0,
        C_DONE = 1'b1
    } cpu_state_e;

    // Which requester the RAM read issued on the previous edge belongs to.
    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_VID    = 2'd1,
        OWN_CPU_RD = 2'd2
    } owner_e;

endpackage

// File: rtl/vram_sp.sv
// Single-port synchronous RAM with registered read data, written to map onto block RAM.
// DEPTH must be a power of two so that the address truncation gives modulo aliasing.
module vram_sp
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int DEPTH  = VRAM_DEPTH
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] dout_q;
    logic [IDX_W-1:0]  idx;

    assign idx  = IDX_W'(addr);
    assign dout = dout_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= din;
            end else begin
                dout_q <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/vram_responder.sv
// Video-RAM responder: fixed two-edge video fetches, with CPU accesses filling the
// RAM slots that video does not claim.
module vram_responder
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int DEPTH  = VRAM_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ready
);

    cpu_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              vid_pend_q, vid_pend_d;
    logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic [DATA_W-1:0] vid_hold_q, vid_hold_d;
    logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;

    logic              cpu_grant;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout;

    // A pending video fetch always owns the slot; the CPU only gets edges video leaves free.
    // The RAM is gated off during reset so a held cs cannot write before it is serviced.
    always_comb begin
        cpu_grant   = !vid_pend_q && (state_q == C_IDLE) && cpu_cs;
        ram_en      = reset_n && (vid_pend_q || cpu_grant);
        ram_we      = cpu_grant && cpu_we;
        ram_addr    = vid_pend_q ? vid_addr_q : cpu_addr;

        vid_pend_d  = vid_req;
        vid_addr_d  = vid_req ? vid_addr : vid_addr_q;
        cpu_ready_d = cpu_grant;

        owner_d = OWN_NONE;
        if (vid_pend_q) begin
            owner_d = OWN_VID;
        end else if (cpu_grant && !cpu_we) begin
            owner_d = OWN_CPU_RD;
        end

        state_d = state_q;
        case (state_q)
            C_IDLE: if (cpu_grant) state_d = C_DONE;
            C_DONE: if (!cpu_cs)   state_d = C_IDLE;
        endcase

        vid_hold_d = (owner_q == OWN_VID)    ? ram_dout : vid_hold_q;
        cpu_hold_d = (owner_q == OWN_CPU_RD) ? ram_dout : cpu_hold_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= C_IDLE;
            owner_q     <= OWN_NONE;
            vid_pend_q  <= 1'b0;
            vid_addr_q  <= '0;
            cpu_ready_q <= 1'b0;
            vid_hold_q  <= '0;
            cpu_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            vid_pend_q  <= vid_pend_d;
            vid_addr_q  <= vid_addr_d;
            cpu_ready_q <= cpu_ready_d;
            vid_hold_q  <= vid_hold_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    // Fresh RAM data is passed straight through on the owner's cycle, then held locally.
    assign vid_valid = (owner_q == OWN_VID);
    assign vid_data  = vid_valid ? ram_dout : vid_hold_q;
    assign cpu_dout  = (owner_q == OWN_CPU_RD) ? ram_dout : cpu_hold_q;
    assign cpu_ready = cpu_ready_q;

    vram_sp #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk (clk),
        .en  (ram_en),
        .we  (ram_we),
        .addr(ram_addr),
        .din (cpu_din),
        .dout(ram_dout)
    );

endmodule

// File: tb/tb_vram_responder.sv
// Directed and soak bench for vram_responder: reset, CPU access, video fetch timing,
// collisions, held chip-select and reset during an access.
module tb_vram_responder;
    import vram_pkg::*;

    localparam int AW          = VRAM_ADDR_W;
    localparam int DW          = VRAM_DATA_W;
    localparam int SOAK_CYCLES = 6000;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } vid_exp_t;

    logic          clk;
    logic          reset_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          cpu_cs;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic          cpu_ready;

    int       total;
    int       bad;
    int       rdy_cnt;
    int       cyc;
    int       acc_lat;
    int       acc_exp_lat;
    int       issued;
    int       readies;
    logic     acc_active;
    logic     gap;
    logic     prev_req;
    logic     exp_valid;
    logic [DW-1:0] model [32];
    vid_exp_t vq[$];

    vram_responder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_data (vid_data),
        .vid_valid(vid_valid),
        .cpu_cs   (cpu_cs),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .cpu_ready(cpu_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                    input int exp_lat, input logic check_rd,
                                    input logic [DW-1:0] exp_dout, input string tag);
        int lat;
        cpu_cs   = 1'b1;
        cpu_we   = we;
        cpu_addr = a;
        cpu_din  = d;
        lat      = 0;
        do begin
            tick();
            lat++;
        end while (!cpu_ready && lat < 8);
        check_output({tag, "_ready"}, 32'(cpu_ready), 32'd1);
        check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (check_rd) check_output({tag, "_dout"}, 32'(cpu_dout), 32'(exp_dout));
        cpu_cs = 1'b0;
        tick();
        check_output({tag, "_ready_width"}, 32'(cpu_ready), 32'd0);
        if (check_rd) check_output({tag, "_dout_hold"}, 32'(cpu_dout), 32'(exp_dout));
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset_n  = 1'b0;
        vid_req  = 1'b0;
        vid_addr = '0;
        cpu_cs   = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = '0;
        cpu_din  = '0;
        #1;
        check_output("por_vid_data", 32'(vid_data), 32'h00);
        check_output("por_vid_valid", 32'(vid_valid), 32'd0);
        check_output("por_cpu_ready", 32'(cpu_ready), 32'd0);
        check_output("por_cpu_dout", 32'(cpu_dout), 32'h00);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // CPU write then read back
        apply_cpu_access(1'b1, 13'h01A5, 8'h5A, 1, 1'b0, 8'h00, "wr_01a5");
        apply_cpu_access(1'b0, 13'h01A5, 8'h00, 1, 1'b1, 8'h5A, "rd_01a5");

        // Single video fetch: valid after the second edge, data held afterwards
        vid_req  = 1'b1;
        vid_addr = 13'h01A5;
        tick();
        check_output("vf_valid_e0", 32'(vid_valid), 32'd0);
        vid_req = 1'b0;
        tick();
        check_output("vf_valid_e1", 32'(vid_valid), 32'd1);
        check_output("vf_data_e1", 32'(vid_data), 32'h5A);
        tick();
        check_output("vf_valid_e2", 32'(vid_valid), 32'd0);
        check_output("vf_data_hold", 32'(vid_data), 32'h5A);

        // Collision: CPU write and video request on the same edge, same address
        cpu_cs   = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 13'h0010;
        cpu_din  = 8'h33;
        vid_req  = 1'b1;
        vid_addr = 13'h0010;
        tick();
        check_output("col_cpu_ready", 32'(cpu_ready), 32'd1);
        check_output("col_vid_valid_e0", 32'(vid_valid), 32'd0);
        cpu_cs  = 1'b0;
        vid_req = 1'b0;
        tick();
        check_output("col_vid_valid_e1", 32'(vid_valid), 32'd1);
        check_output("col_vid_data", 32'(vid_data), 32'h33);
        check_output("col_cpu_ready_width", 32'(cpu_ready), 32'd0);
        tick();

        // Held cs must write exactly once even if din changes afterwards
        cpu_cs   = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 13'h0000;
        cpu_din  = 8'h77;
        rdy_cnt  = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cpu_ready) rdy_cnt++;
            cpu_din = 8'h88;
        end
        check_output("held_ready_count", 32'(rdy_cnt), 32'd1);
        cpu_cs = 1'b0;
        tick();
        apply_cpu_access(1'b0, 13'h0000, 8'h00, 1, 1'b1, 8'h77, "held_readback");

        // Reset during an access: no pulse while reset, serviced once after release
        cpu_cs   = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 13'h0002;
        cpu_din  = 8'h44;
        reset_n  = 1'b0;
        #1;
        check_output("rst_acc_ready_async", 32'(cpu_ready), 32'd0);
        tick();
        check_output("rst_acc_ready_e1", 32'(cpu_ready), 32'd0);
        tick();
        check_output("rst_acc_ready_e2", 32'(cpu_ready), 32'd0);
        reset_n = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpu_ready) rdy_cnt++;
        end
        check_output("rst_acc_redo_count", 32'(rdy_cnt), 32'd1);
        cpu_cs = 1'b0;
        tick();
        apply_cpu_access(1'b0, 13'h0002, 8'h00, 1, 1'b1, 8'h44, "rst_acc_readback");

        // Full-rate streaming: one read per edge while vid_req is held
        vid_req  = 1'b1;
        vid_addr = 13'h0010;
        tick();
        check_output("stream_valid_e0", 32'(vid_valid), 32'd0);
        vid_addr = 13'h01A5;
        tick();
        check_output("stream_valid_1", 32'(vid_valid), 32'd1);
        check_output("stream_data_1", 32'(vid_data), 32'h33);
        vid_addr = 13'h0000;
        tick();
        check_output("stream_valid_2", 32'(vid_valid), 32'd1);
        check_output("stream_data_2", 32'(vid_data), 32'h5A);
        vid_req = 1'b0;
        tick();
        check_output("stream_valid_3", 32'(vid_valid), 32'd1);
        check_output("stream_data_3", 32'(vid_data), 32'h77);
        tick();
        check_output("stream_valid_end", 32'(vid_valid), 32'd0);
        check_output("stream_data_hold", 32'(vid_data), 32'h77);

        // Mid-stream reset: outputs clear at once, pending fetch abandoned, RAM kept
        vid_req  = 1'b1;
        vid_addr = 13'h01A5;
        tick();
        vid_req = 1'b0;
        reset_n = 1'b0;
        #1;
        check_output("rst_vid_data", 32'(vid_data), 32'h00);
        check_output("rst_vid_valid", 32'(vid_valid), 32'd0);
        check_output("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check_output("rst_cpu_dout", 32'(cpu_dout), 32'h00);
        tick();
        check_output("rst_held_valid", 32'(vid_valid), 32'd0);
        reset_n = 1'b1;
        tick();
        check_output("rst_abandon_valid_1", 32'(vid_valid), 32'd0);
        tick();
        check_output("rst_abandon_valid_2", 32'(vid_valid), 32'd0);
        vid_req  = 1'b1;
        vid_addr = 13'h01A5;
        tick();
        vid_req = 1'b0;
        tick();
        check_output("post_rst_valid", 32'(vid_valid), 32'd1);
        check_output("post_rst_data", 32'(vid_data), 32'h5A);
        tick();

        // Soak: known contents in the low 32 words, then vga-like video plus random CPU traffic
        for (int a = 0; a < 32; a++) begin
            model[a] = 8'($urandom);
            apply_cpu_access(1'b1, 13'(a), model[a], 1, 1'b0, 8'h00, "prefill");
        end

        cyc        = 0;
        acc_active = 1'b0;
        gap        = 1'b0;
        issued     = 0;
        readies    = 0;
        acc_lat    = 0;
        acc_exp_lat = 0;
        for (int n = 0; n < SOAK_CYCLES; n++) begin
            prev_req = vid_req;
            vid_req  = (n % 16 == 0) && (n < SOAK_CYCLES - 8);
            if (vid_req) begin
                vid_addr = 13'($urandom_range(0, 31));
                vq.push_back('{vid_addr, cyc + 2});
            end
            if (gap) begin
                gap = 1'b0;
            end else if (!acc_active && n < SOAK_CYCLES - 8 && $urandom_range(0, 3) != 0) begin
                acc_active  = 1'b1;
                acc_lat     = 0;
                acc_exp_lat = prev_req ? 2 : 1;
                cpu_cs      = 1'b1;
                cpu_we      = 1'($urandom_range(0, 1));
                cpu_addr    = 13'($urandom_range(0, 31));
                cpu_din     = 8'($urandom);
                issued++;
            end
            tick();
            cyc++;
            if (acc_active) acc_lat++;
            if (cpu_ready) begin
                check_output("soak_ready_owned", 32'(acc_active), 32'd1);
                if (acc_active) begin
                    readies++;
                    check_output("soak_cpu_latency", 32'(acc_lat), 32'(acc_exp_lat));
                    if (cpu_we) model[cpu_addr[4:0]] = cpu_din;
                    else check_output("soak_cpu_rd", 32'(cpu_dout), 32'(model[cpu_addr[4:0]]));
                    acc_active = 1'b0;
                    cpu_cs     = 1'b0;
                    gap        = 1'b1;
                end
            end else if (acc_active && acc_lat >= 4) begin
                check_output("soak_cpu_timeout", 32'(acc_lat), 32'(acc_exp_lat));
                acc_active = 1'b0;
                cpu_cs     = 1'b0;
                gap        = 1'b1;
            end
            exp_valid = (vq.size() > 0) && (vq[0].due == cyc);
            check_output("soak_vid_valid", 32'(vid_valid), 32'(exp_valid));
            if (exp_valid) begin
                check_output("soak_vid_data", 32'(vid_data), 32'(model[vq[0].addr[4:0]]));
                void'(vq.pop_front());
            end
        end
        check_output("soak_ready_count", 32'(readies), 32'(issued));
        check_output("soak_vid_drained", 32'(vq.size()), 32'd0);
        check_output("soak_acc_idle", 32'(acc_active), 32'd0);
        tick();
        for (int a = 0; a < 32; a++) begin
            apply_cpu_access(1'b0, 13'(a), 8'h00, 1, 1'b1, model[a], "soak_readback");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
